sy_axi4_rw_arbiter: RTL and testbench

SY_AXI4_RW_ARBITER -- requirements
Module: sy_axi4_rw_arbiter

---
 rtl/axi_pkg.sv | 49 ++++
 rtl/sy_pkg.sv | 21 ++
 rtl/rr_arb_tree.sv | 79 +++++++
 rtl/sy_axi4_rw_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sy_axi4_rw_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_pkg
// Brief    : AXI4 channel payload types shared by requesters and the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package axi_pkg;

    localparam int unsigned c_ID_W   = 4;
    localparam int unsigned c_ADDR_W = 32;
    localparam int unsigned c_DATA_W = 32;
    localparam int unsigned c_STRB_W = c_DATA_W / 8;

    typedef struct packed {
        logic [c_ID_W-1:0]   id;
        logic [c_ADDR_W-1:0] addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
    } aw_chan_t;

    typedef struct packed {
        logic [c_ID_W-1:0]   id;
        logic [c_ADDR_W-1:0] addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
    } ar_chan_t;

    typedef struct packed {
        logic [c_DATA_W-1:0] data;
        logic [c_STRB_W-1:0] strb;
        logic                last;
    } w_chan_t;

    typedef struct packed {
        logic [c_ID_W-1:0]   id;
        logic [c_DATA_W-1:0] data;
        logic [1:0]          resp;
        logic                last;
    } r_chan_t;

    typedef struct packed {
        logic [c_ID_W-1:0] id;
        logic [1:0]        resp;
    } b_chan_t;

endpackage
`default_nettype wire

// File: rtl/sy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sy_pkg
// Brief    : State encodings for the read and write arbitration FSMs.
// Revision : 1.0 - initial release
// ============================================================================
package sy_pkg;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arb_tree.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_tree
// Brief    : Round-robin arbiter with optional grant lock while stalled.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb_tree #(
    parameter int unsigned NUM_IN     = 2,
    parameter int unsigned DATA_WIDTH = 1,
    parameter bit          LOCK_IN    = 1'b1,
    localparam int unsigned IDX_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_IN-1:0]                   i_req,
    output logic [NUM_IN-1:0]                   o_gnt,
    input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]   i_data,
    output logic                                o_req,
    input  logic                                i_gnt,
    output logic [DATA_WIDTH-1:0]               o_data,
    output logic [IDX_W-1:0]                    o_idx
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_lock_idx;
    logic             r_locked;
    logic [IDX_W-1:0] w_rr_idx;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_cand_idx;
    logic             w_any;
    logic             w_lock_act;
    int               w_cand;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        w_rr_idx   = r_ptr;
        w_any      = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            w_cand = int'(r_ptr) + k;
            if (w_cand >= int'(NUM_IN)) begin
                w_cand = w_cand - int'(NUM_IN);
            end
            w_cand_idx = IDX_W'(w_cand);
            if (!w_any && i_req[w_cand_idx]) begin
                w_any    = 1'b1;
                w_rr_idx = w_cand_idx;
            end
        end
    end

    assign w_lock_act = LOCK_IN && r_locked;
    assign w_idx      = w_lock_act ? r_lock_idx : w_rr_idx;
    assign o_idx      = w_idx;
    assign o_req      = w_lock_act ? i_req[r_lock_idx] : w_any;
    assign o_data     = i_data[w_idx];

    always_comb begin
        o_gnt        = '0;
        o_gnt[w_idx] = o_req & i_gnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_lock_idx <= '0;
            r_locked   <= 1'b0;
        end else begin
            r_locked   <= o_req & ~i_gnt;
            r_lock_idx <= w_idx;
            if (o_req && i_gnt) begin
                r_ptr <= (w_idx == IDX_W'(NUM_IN - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sy_axi4_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sy_axi4_rw_arbiter
// Brief    : N:1 AXI4 arbiter with independent read and write burst paths.
// Revision : 1.0 - initial release
// ============================================================================
module sy_axi4_rw_arbiter
    import sy_pkg::*;
#(
    parameter int unsigned PORT_NUM = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [PORT_NUM-1:0]                   inp_axi_aw_valid_i,
    input  logic [PORT_NUM-1:0]                   inp_axi_ar_valid_i,
    input  logic [PORT_NUM-1:0]                   inp_axi_w_valid_i,
    output logic [PORT_NUM-1:0]                   inp_axi_aw_ready_o,
    output logic [PORT_NUM-1:0]                   inp_axi_ar_ready_o,
    output logic [PORT_NUM-1:0]                   inp_axi_w_ready_o,
    input  axi_pkg::aw_chan_t [PORT_NUM-1:0]      inp_axi_aw_bits_i,
    input  axi_pkg::ar_chan_t [PORT_NUM-1:0]      inp_axi_ar_bits_i,
    input  axi_pkg::w_chan_t  [PORT_NUM-1:0]      inp_axi_w_bits_i,
    output logic [PORT_NUM-1:0]                   inp_axi_r_valid_o,
    output logic [PORT_NUM-1:0]                   inp_axi_b_valid_o,
    input  logic [PORT_NUM-1:0]                   inp_axi_r_ready_i,
    input  logic [PORT_NUM-1:0]                   inp_axi_b_ready_i,
    output axi_pkg::r_chan_t  [PORT_NUM-1:0]      inp_axi_r_bits_o,
    output axi_pkg::b_chan_t  [PORT_NUM-1:0]      inp_axi_b_bits_o,
    output logic                                  oup_axi_aw_valid_o,
    input  logic                                  oup_axi_aw_ready_i,
    output axi_pkg::aw_chan_t                     oup_axi_aw_bits_o,
    output logic                                  oup_axi_ar_valid_o,
    input  logic                                  oup_axi_ar_ready_i,
    output axi_pkg::ar_chan_t                     oup_axi_ar_bits_o,
    output logic                                  oup_axi_w_valid_o,
    input  logic                                  oup_axi_w_ready_i,
    output axi_pkg::w_chan_t                      oup_axi_w_bits_o,
    input  logic                                  oup_axi_r_valid_i,
    output logic                                  oup_axi_r_ready_o,
    input  axi_pkg::r_chan_t                      oup_axi_r_bits_i,
    input  logic                                  oup_axi_b_valid_i,
    output logic                                  oup_axi_b_ready_o,
    input  axi_pkg::b_chan_t                      oup_axi_b_bits_i
);

    localparam int unsigned c_IDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    rd_state_e            r_rd_state;
    rd_state_e            w_rd_state_nxt;
    logic [c_IDX_W-1:0]   r_rd_sel;
    logic [c_IDX_W-1:0]   w_rd_sel_nxt;

    wr_state_e            r_wr_state;
    wr_state_e            w_wr_state_nxt;
    logic [c_IDX_W-1:0]   r_wr_sel;
    logic [c_IDX_W-1:0]   w_wr_sel_nxt;
    logic [7:0]           r_beat_cnt;
    logic [7:0]           w_beat_cnt_nxt;

    logic [PORT_NUM-1:0]  w_ar_req;
    logic [PORT_NUM-1:0]  w_aw_req;
    logic                 w_ar_arb_req;
    logic                 w_aw_arb_req;
    logic                 w_ar_arb_data;
    logic                 w_aw_arb_data;
    logic [c_IDX_W-1:0]   w_ar_idx;
    logic [c_IDX_W-1:0]   w_aw_idx;

    // Requests are only offered to an arbiter while its FSM is idle and out of reset.
    assign w_ar_req = inp_axi_ar_valid_i & {PORT_NUM{(r_rd_state == R_IDLE) && !rst_i}};
    assign w_aw_req = inp_axi_aw_valid_i & {PORT_NUM{(r_wr_state == W_IDLE) && !rst_i}};

    rr_arb_tree #(
        .NUM_IN     (PORT_NUM),
        .DATA_WIDTH (1),
        .LOCK_IN    (1'b1)
    ) u_ar_arb (
        .clk    (clk_i),
        .rst    (rst_i),
        .i_req  (w_ar_req),
        .o_gnt  (inp_axi_ar_ready_o),
        .i_data (w_ar_req),
        .o_req  (w_ar_arb_req),
        .i_gnt  (oup_axi_ar_ready_i),
        .o_data (w_ar_arb_data),
        .o_idx  (w_ar_idx)
    );

    rr_arb_tree #(
        .NUM_IN     (PORT_NUM),
        .DATA_WIDTH (1),
        .LOCK_IN    (1'b1)
    ) u_aw_arb (
        .clk    (clk_i),
        .rst    (rst_i),
        .i_req  (w_aw_req),
        .o_gnt  (inp_axi_aw_ready_o),
        .i_data (w_aw_req),
        .o_req  (w_aw_arb_req),
        .i_gnt  (oup_axi_aw_ready_i),
        .o_data (w_aw_arb_data),
        .o_idx  (w_aw_idx)
    );

    assign oup_axi_ar_valid_o = w_ar_arb_req & w_ar_arb_data;
    assign oup_axi_ar_bits_o  = inp_axi_ar_bits_i[w_ar_idx];
    assign oup_axi_aw_valid_o = w_aw_arb_req & w_aw_arb_data;
    assign oup_axi_aw_bits_o  = inp_axi_aw_bits_i[w_aw_idx];
    assign oup_axi_w_bits_o   = inp_axi_w_bits_i[r_wr_sel];

    // Response payloads fan out to every port; only valid is steered.
    assign inp_axi_r_bits_o = {PORT_NUM{oup_axi_r_bits_i}};
    assign inp_axi_b_bits_o = {PORT_NUM{oup_axi_b_bits_i}};

    always_comb begin
        w_rd_state_nxt    = r_rd_state;
        w_rd_sel_nxt      = r_rd_sel;
        inp_axi_r_valid_o = '0;
        oup_axi_r_ready_o = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (oup_axi_ar_valid_o && oup_axi_ar_ready_i) begin
                    w_rd_sel_nxt   = w_ar_idx;
                    w_rd_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                inp_axi_r_valid_o[r_rd_sel] = oup_axi_r_valid_i;
                oup_axi_r_ready_o           = inp_axi_r_ready_i[r_rd_sel];
                if (oup_axi_r_valid_i && inp_axi_r_ready_i[r_rd_sel] && oup_axi_r_bits_i.last) begin
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_wr_state_nxt    = r_wr_state;
        w_wr_sel_nxt      = r_wr_sel;
        w_beat_cnt_nxt    = r_beat_cnt;
        oup_axi_w_valid_o = 1'b0;
        inp_axi_w_ready_o = '0;
        inp_axi_b_valid_o = '0;
        oup_axi_b_ready_o = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (oup_axi_aw_valid_o && oup_axi_aw_ready_i) begin
                    w_wr_sel_nxt   = w_aw_idx;
                    w_beat_cnt_nxt = oup_axi_aw_bits_o.len;
                    w_wr_state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                oup_axi_w_valid_o           = inp_axi_w_valid_i[r_wr_sel];
                inp_axi_w_ready_o[r_wr_sel] = oup_axi_w_ready_i;
                // Counter holds remaining beats minus one; the zero beat closes the burst.
                if (inp_axi_w_valid_i[r_wr_sel] && oup_axi_w_ready_i) begin
                    if (r_beat_cnt == 8'd0) begin
                        w_wr_state_nxt = W_RESP;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt - 8'd1;
                    end
                end
            end
            W_RESP: begin
                inp_axi_b_valid_o[r_wr_sel] = oup_axi_b_valid_i;
                oup_axi_b_ready_o           = inp_axi_b_ready_i[r_wr_sel];
                if (oup_axi_b_valid_i && inp_axi_b_ready_i[r_wr_sel]) begin
                    w_wr_state_nxt = W_IDLE;
                end
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_state <= R_IDLE;
            r_rd_sel   <= '0;
            r_wr_state <= W_IDLE;
            r_wr_sel   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_rd_sel   <= w_rd_sel_nxt;
            r_wr_state <= w_wr_state_nxt;
            r_wr_sel   <= w_wr_sel_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sy_axi4_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sy_axi4_rw_arbiter
// Brief    : Directed self-checking bench for the AXI4 read/write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sy_axi4_rw_arbiter;
    import axi_pkg::*;

    localparam int unsigned N = 2;

    logic clk_i = 1'b0;
    logic rst_i;

    logic [N-1:0] aw_valid, ar_valid, w_valid;
    logic [N-1:0] aw_ready, ar_ready, w_ready;
    aw_chan_t [N-1:0] aw_bits;
    ar_chan_t [N-1:0] ar_bits;
    w_chan_t  [N-1:0] w_bits;
    logic [N-1:0] r_valid, b_valid, r_ready, b_ready;
    r_chan_t  [N-1:0] r_bits;
    b_chan_t  [N-1:0] b_bits;

    logic     o_aw_valid, o_aw_ready, o_ar_valid, o_ar_ready, o_w_valid, o_w_ready;
    aw_chan_t o_aw_bits;
    ar_chan_t o_ar_bits;
    w_chan_t  o_w_bits;
    logic     o_r_valid, o_r_ready, o_b_valid, o_b_ready;
    r_chan_t  o_r_bits;
    b_chan_t  o_b_bits;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    sy_axi4_rw_arbiter #(.PORT_NUM(N)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .inp_axi_aw_valid_i (aw_valid),
        .inp_axi_ar_valid_i (ar_valid),
        .inp_axi_w_valid_i  (w_valid),
        .inp_axi_aw_ready_o (aw_ready),
        .inp_axi_ar_ready_o (ar_ready),
        .inp_axi_w_ready_o  (w_ready),
        .inp_axi_aw_bits_i  (aw_bits),
        .inp_axi_ar_bits_i  (ar_bits),
        .inp_axi_w_bits_i   (w_bits),
        .inp_axi_r_valid_o  (r_valid),
        .inp_axi_b_valid_o  (b_valid),
        .inp_axi_r_ready_i  (r_ready),
        .inp_axi_b_ready_i  (b_ready),
        .inp_axi_r_bits_o   (r_bits),
        .inp_axi_b_bits_o   (b_bits),
        .oup_axi_aw_valid_o (o_aw_valid),
        .oup_axi_aw_ready_i (o_aw_ready),
        .oup_axi_aw_bits_o  (o_aw_bits),
        .oup_axi_ar_valid_o (o_ar_valid),
        .oup_axi_ar_ready_i (o_ar_ready),
        .oup_axi_ar_bits_o  (o_ar_bits),
        .oup_axi_w_valid_o  (o_w_valid),
        .oup_axi_w_ready_i  (o_w_ready),
        .oup_axi_w_bits_o   (o_w_bits),
        .oup_axi_r_valid_i  (o_r_valid),
        .oup_axi_r_ready_o  (o_r_ready),
        .oup_axi_r_bits_i   (o_r_bits),
        .oup_axi_b_valid_i  (o_b_valid),
        .oup_axi_b_ready_o  (o_b_ready),
        .oup_axi_b_bits_i   (o_b_bits)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    function automatic aw_chan_t mk_aw(input logic [31:0] a, input logic [7:0] l);
        mk_aw = '{id: 4'd1, addr: a, len: l, size: 3'd2, burst: 2'b01};
    endfunction

    function automatic ar_chan_t mk_ar(input logic [31:0] a, input logic [7:0] l);
        mk_ar = '{id: 4'd2, addr: a, len: l, size: 3'd2, burst: 2'b01};
    endfunction

    initial begin
        rst_i      = 1'b1;
        aw_bits    = '0;
        ar_bits    = '0;
        w_bits     = '0;
        r_ready    = 2'b11;
        b_ready    = 2'b11;
        o_r_valid  = 1'b0;
        o_b_valid  = 1'b0;
        o_r_bits   = '0;
        o_b_bits   = '0;
        // Everything requesting while reset is held: nothing may leak out.
        ar_valid   = 2'b01;
        aw_valid   = 2'b11;
        w_valid    = 2'b11;
        o_aw_ready = 1'b1;
        o_ar_ready = 1'b1;
        o_w_ready  = 1'b1;
        #2;
        chk("rst_ar_valid", o_ar_valid, 1'b0);
        chk("rst_aw_valid", o_aw_valid, 1'b0);
        chk("rst_ar_ready", ar_ready, 2'b00);
        chk("rst_aw_ready", aw_ready, 2'b00);
        chk("rst_w_ready", w_ready, 2'b00);
        chk("rst_w_valid", o_w_valid, 1'b0);
        chk("rst_r_ready", o_r_ready, 1'b0);
        chk("rst_b_ready", o_b_ready, 1'b0);
        chk("rst_r_valid", r_valid, 2'b00);
        chk("rst_b_valid", b_valid, 2'b00);
        cyc();
        cyc();
        ar_valid   = 2'b00;
        aw_valid   = 2'b00;
        w_valid    = 2'b00;
        o_aw_ready = 1'b0;
        o_w_ready  = 1'b0;
        rst_i      = 1'b0;

        // Port0 read burst, len=3
        cyc();
        ar_valid   = 2'b01;
        ar_bits[0] = mk_ar(32'h1000, 8'd3);
        ar_bits[1] = mk_ar(32'h2000, 8'd0);
        #1;
        chk("ar0_valid", o_ar_valid, 1'b1);
        chk("ar0_addr", o_ar_bits.addr, 32'h1000);
        chk("ar0_ready", ar_ready, 2'b01);
        cyc();
        ar_valid  = 2'b10;
        o_r_valid = 1'b1;
        o_r_bits  = '{id: 4'd2, data: 32'hA0, resp: 2'b00, last: 1'b0};
        #1;
        chk("ar_busy_valid", o_ar_valid, 1'b0);
        chk("ar_busy_ready", ar_ready, 2'b00);
        chk("r0_beat0_valid", r_valid, 2'b01);
        chk("r0_beat0_ready", o_r_ready, 1'b1);
        chk("r_bcast_data", r_bits[1].data, 32'hA0);
        for (int k = 1; k < 4; k++) begin
            cyc();
            o_r_bits.data = 32'hA0 + 32'(k);
            o_r_bits.last = (k == 3);
            #1;
            chk("r0_beat_valid", r_valid, 2'b01);
        end
        cyc();
        o_r_valid = 1'b0;
        #1;
        chk("ar1_valid", o_ar_valid, 1'b1);
        chk("ar1_addr", o_ar_bits.addr, 32'h2000);
        chk("ar1_ready", ar_ready, 2'b10);
        cyc();
        ar_valid  = 2'b00;
        o_r_valid = 1'b1;
        o_r_bits  = '{id: 4'd2, data: 32'hB0, resp: 2'b00, last: 1'b1};
        r_ready   = 2'b01;
        #1;
        chk("r1_valid", r_valid, 2'b10);
        chk("r1_ready_sel_lo", o_r_ready, 1'b0);
        r_ready = 2'b11;
        #1;
        chk("r1_ready_sel_hi", o_r_ready, 1'b1);
        cyc();
        o_r_valid = 1'b0;
        #1;
        chk("r_idle_valid", r_valid, 2'b00);
        chk("ar_idle_valid", o_ar_valid, 1'b0);

        // Both ports write at once, len=0; W arriving before AW is held off
        o_aw_ready = 1'b1;
        o_w_ready  = 1'b1;
        aw_valid   = 2'b11;
        aw_bits[0] = mk_aw(32'h3000, 8'd0);
        aw_bits[1] = mk_aw(32'h4000, 8'd0);
        w_valid    = 2'b11;
        w_bits[0]  = '{data: 32'h1111, strb: 4'hF, last: 1'b1};
        w_bits[1]  = '{data: 32'h2222, strb: 4'hF, last: 1'b1};
        #1;
        chk("aw0_valid", o_aw_valid, 1'b1);
        chk("aw0_addr", o_aw_bits.addr, 32'h3000);
        chk("aw0_ready", aw_ready, 2'b01);
        chk("w_early_ready", w_ready, 2'b00);
        chk("w_early_valid", o_w_valid, 1'b0);
        cyc();
        aw_valid = 2'b10;
        #1;
        chk("aw_busy_valid", o_aw_valid, 1'b0);
        chk("w0_valid", o_w_valid, 1'b1);
        chk("w0_data", o_w_bits.data, 32'h1111);
        chk("w0_ready", w_ready, 2'b01);
        cyc();
        w_valid   = 2'b10;
        o_b_valid = 1'b1;
        o_b_bits  = '{id: 4'd5, resp: 2'b00};
        #1;
        chk("b0_valid", b_valid, 2'b01);
        chk("b0_ready", o_b_ready, 1'b1);
        chk("wresp_w_ready", w_ready, 2'b00);
        chk("b_bcast_id", b_bits[1].id, 4'd5);
        cyc();
        o_b_valid = 1'b0;
        #1;
        chk("aw1_valid", o_aw_valid, 1'b1);
        chk("aw1_addr", o_aw_bits.addr, 32'h4000);
        chk("aw1_ready", aw_ready, 2'b10);
        cyc();
        aw_valid = 2'b00;
        #1;
        chk("w1_data", o_w_bits.data, 32'h2222);
        chk("w1_ready", w_ready, 2'b10);
        cyc();
        w_valid   = 2'b00;
        o_b_valid = 1'b1;
        #1;
        chk("b1_valid", b_valid, 2'b10);
        cyc();
        o_b_valid = 1'b0;
        #1;
        chk("b_idle_valid", b_valid, 2'b00);

        // Downstream stalls AW for 3 cycles; pointer is back at port0
        o_aw_ready = 1'b0;
        aw_bits[0] = mk_aw(32'h3000, 8'd3);
        aw_valid   = 2'b11;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk("stall_valid", o_aw_valid, 1'b1);
            chk("stall_addr", o_aw_bits.addr, 32'h3000);
            chk("stall_ready", aw_ready, 2'b00);
        end
        cyc();
        o_aw_ready = 1'b1;
        #1;
        chk("stall_release_ready", aw_ready, 2'b01);
        chk("stall_release_len", o_aw_bits.len, 8'd3);
        cyc();
        aw_valid  = 2'b10;
        w_valid   = 2'b01;
        w_bits[0] = '{data: 32'h5555, strb: 4'hF, last: 1'b0};
        #1;
        chk("w4_beat0_ready", w_ready, 2'b01);
        chk("w4_aw_busy", o_aw_valid, 1'b0);

        // Reset after the 2nd of 4 beats
        cyc();
        #1;
        chk("w4_beat1_ready", w_ready, 2'b01);
        cyc();
        rst_i = 1'b1;
        #1;
        chk("mid_rst_w_valid", o_w_valid, 1'b0);
        chk("mid_rst_w_ready", w_ready, 2'b00);
        chk("mid_rst_aw_valid", o_aw_valid, 1'b0);
        chk("mid_rst_aw_ready", aw_ready, 2'b00);
        chk("mid_rst_b_ready", o_b_ready, 1'b0);
        cyc();
        rst_i      = 1'b0;
        w_valid    = 2'b00;
        aw_bits[1] = mk_aw(32'h7000, 8'd0);
        #1;
        chk("post_rst_aw_valid", o_aw_valid, 1'b1);
        chk("post_rst_aw_addr", o_aw_bits.addr, 32'h7000);
        chk("post_rst_aw_ready", aw_ready, 2'b10);
        chk("post_rst_w_valid", o_w_valid, 1'b0);
        cyc();
        aw_valid  = 2'b00;
        w_valid   = 2'b10;
        w_bits[1] = '{data: 32'h6666, strb: 4'hF, last: 1'b1};
        #1;
        chk("post_rst_w_ready", w_ready, 2'b10);
        chk("post_rst_w_data", o_w_bits.data, 32'h6666);
        cyc();
        w_valid   = 2'b00;
        o_b_valid = 1'b1;
        #1;
        chk("post_rst_b_valid", b_valid, 2'b10);
        cyc();
        o_b_valid = 1'b0;

        // Port1 read len=1 overlapping port0 write len=1
        ar_valid   = 2'b10;
        ar_bits[1] = mk_ar(32'h5000, 8'd1);
        aw_valid   = 2'b01;
        aw_bits[0] = mk_aw(32'h6000, 8'd1);
        #1;
        chk("ovl_ar_valid", o_ar_valid, 1'b1);
        chk("ovl_ar_addr", o_ar_bits.addr, 32'h5000);
        chk("ovl_ar_ready", ar_ready, 2'b10);
        chk("ovl_aw_valid", o_aw_valid, 1'b1);
        chk("ovl_aw_addr", o_aw_bits.addr, 32'h6000);
        chk("ovl_aw_ready", aw_ready, 2'b01);
        cyc();
        ar_valid  = 2'b00;
        aw_valid  = 2'b00;
        o_r_valid = 1'b1;
        o_r_bits  = '{id: 4'd2, data: 32'hC0, resp: 2'b00, last: 1'b0};
        w_valid   = 2'b01;
        w_bits[0] = '{data: 32'h3333, strb: 4'hF, last: 1'b0};
        #1;
        chk("ovl_r0_valid", r_valid, 2'b10);
        chk("ovl_w0_ready", w_ready, 2'b01);
        chk("ovl_w0_data", o_w_bits.data, 32'h3333);
        cyc();
        o_r_bits.data = 32'hC1;
        o_r_bits.last = 1'b1;
        #1;
        chk("ovl_r1_valid", r_valid, 2'b10);
        chk("ovl_w1_ready", w_ready, 2'b01);
        cyc();
        o_r_valid = 1'b0;
        w_valid   = 2'b00;
        o_b_valid = 1'b1;
        o_b_bits  = '{id: 4'd9, resp: 2'b00};
        #1;
        chk("ovl_b_valid", b_valid, 2'b01);
        chk("ovl_r_done", r_valid, 2'b00);
        chk("ovl_w_done", w_ready, 2'b00);
        chk("ovl_b_id", b_bits[0].id, 4'd9);
        cyc();
        o_b_valid = 1'b0;
        #1;
        chk("ovl_b_idle", b_valid, 2'b00);

        // Same port raises AR and AW together
        ar_valid   = 2'b01;
        ar_bits[0] = mk_ar(32'h8000, 8'd0);
        aw_valid   = 2'b01;
        aw_bits[0] = mk_aw(32'h9000, 8'd0);
        #1;
        chk("dual_ar_ready", ar_ready, 2'b01);
        chk("dual_aw_ready", aw_ready, 2'b01);
        cyc();
        ar_valid  = 2'b00;
        aw_valid  = 2'b00;
        o_r_valid = 1'b1;
        w_valid   = 2'b01;
        #1;
        chk("dual_r_valid", r_valid, 2'b01);
        chk("dual_w_ready", w_ready, 2'b01);
        cyc();
        o_r_valid = 1'b0;
        w_valid   = 2'b00;
        o_b_valid = 1'b1;
        #1;
        chk("dual_b_valid", b_valid, 2'b01);
        cyc();
        o_b_valid = 1'b0;
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
